// File: rtl/line_pkg.sv
// Shared definitions for the line command queue: MMIO offsets, command entry
// layout and sequencer state encodings.
package line_pkg;

   localparam logic [2:0] OFF_X0   = 3'd0;
   localparam logic [2:0] OFF_Y0   = 3'd1;
   localparam logic [2:0] OFF_X1   = 3'd2;
   localparam logic [2:0] OFF_Y1   = 3'd3;
   localparam logic [2:0] OFF_COL  = 3'd4;
   localparam logic [2:0] OFF_TRIG = 3'd5;
   localparam logic [2:0] OFF_CLR  = 3'd6;

   localparam int CMD_W = 104;

   typedef struct packed {
      logic [9:0]  x0;
      logic [9:0]  y0;
      logic [9:0]  x1;
      logic [9:0]  y1;
      logic [31:0] color;
      logic [31:0] frame_base;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_X0,
      S_LD_Y0,
      S_LD_X1,
      S_LD_Y1,
      S_LD_COL,
      S_TRIG
   } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only when a
// pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/line_cmd_queue.sv
// MMIO command buffer for the line engine: staging registers, a command FIFO
// and a sequencer that replays each queued command into the engine's load port.
module line_cmd_queue
   import line_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_addr,
   input  logic [31:0] cpu_din,
   output logic [31:0] cpu_dout,
   input  logic [31:0] frame_base,
   input  logic        LE_ready,
   output logic [9:0]  LE_point,
   output logic [31:0] LE_color,
   output logic        LE_x0_valid,
   output logic        LE_y0_valid,
   output logic        LE_x1_valid,
   output logic        LE_y1_valid,
   output logic        LE_color_valid,
   output logic        LE_trigger,
   output logic [31:0] LE_frame_base,
   output logic        q_busy
);

   logic [9:0]  stg_x0, stg_y0, stg_x1, stg_y1;
   logic [31:0] stg_color;
   logic        overflow;
   cmd_t        new_cmd;
   cmd_t        head;
   logic        full, empty, pop, push_req, push_ok;
   logic [CW-1:0] count;
   seq_state_t  state;

   assign new_cmd  = {stg_x0, stg_y0, stg_x1, stg_y1, stg_color, frame_base};
   assign push_req = cpu_we && (cpu_addr == OFF_TRIG);
   assign pop      = (state == S_TRIG);
   assign push_ok  = push_req && (!full || pop);
   assign q_busy   = !empty || (state != S_IDLE) || !LE_ready;
   assign cpu_dout = {16'b0, 12'(count), overflow, q_busy, full, empty};

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (pop),
      .din   (new_cmd),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Staging registers persist across pushes; overflow set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_x0    <= '0;
         stg_y0    <= '0;
         stg_x1    <= '0;
         stg_y1    <= '0;
         stg_color <= '0;
         overflow  <= 1'b0;
      end else begin
         if (cpu_we) begin
            case (cpu_addr)
               OFF_X0:  stg_x0    <= cpu_din[9:0];
               OFF_Y0:  stg_y0    <= cpu_din[9:0];
               OFF_X1:  stg_x1    <= cpu_din[9:0];
               OFF_Y1:  stg_y1    <= cpu_din[9:0];
               OFF_COL: stg_color <= cpu_din;
               default: ;
            endcase
         end
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (cpu_we && (cpu_addr == OFF_CLR))
            overflow <= 1'b0;
      end
   end

   // Outputs are registered alongside the state, zero whenever their strobe is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         LE_point       <= '0;
         LE_color       <= '0;
         LE_frame_base  <= '0;
         LE_x0_valid    <= 1'b0;
         LE_y0_valid    <= 1'b0;
         LE_x1_valid    <= 1'b0;
         LE_y1_valid    <= 1'b0;
         LE_color_valid <= 1'b0;
         LE_trigger     <= 1'b0;
      end else begin
         LE_point       <= '0;
         LE_color       <= '0;
         LE_frame_base  <= '0;
         LE_x0_valid    <= 1'b0;
         LE_y0_valid    <= 1'b0;
         LE_x1_valid    <= 1'b0;
         LE_y1_valid    <= 1'b0;
         LE_color_valid <= 1'b0;
         LE_trigger     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!empty && LE_ready) begin
                  state       <= S_LD_X0;
                  LE_x0_valid <= 1'b1;
                  LE_point    <= head.x0;
               end
            end
            S_LD_X0: begin
               state       <= S_LD_Y0;
               LE_y0_valid <= 1'b1;
               LE_point    <= head.y0;
            end
            S_LD_Y0: begin
               state       <= S_LD_X1;
               LE_x1_valid <= 1'b1;
               LE_point    <= head.x1;
            end
            S_LD_X1: begin
               state       <= S_LD_Y1;
               LE_y1_valid <= 1'b1;
               LE_point    <= head.y1;
            end
            S_LD_Y1: begin
               state          <= S_LD_COL;
               LE_color_valid <= 1'b1;
               LE_color       <= head.color;
            end
            S_LD_COL: begin
               state         <= S_TRIG;
               LE_trigger    <= 1'b1;
               LE_frame_base <= head.frame_base;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_cmd_queue.sv
// Directed bench for line_cmd_queue: MMIO pushes, ordered drains, overflow,
// push-during-pop, async reset and frame base capture.
module tb_line_cmd_queue;
   import line_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_we;
   logic [2:0]  cpu_addr;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic [31:0] frame_base;
   logic        LE_ready;
   logic [9:0]  LE_point;
   logic [31:0] LE_color;
   logic        LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
   logic        LE_color_valid, LE_trigger;
   logic [31:0] LE_frame_base;
   logic        q_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   line_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_din        (cpu_din),
      .cpu_dout       (cpu_dout),
      .frame_base     (frame_base),
      .LE_ready       (LE_ready),
      .LE_point       (LE_point),
      .LE_color       (LE_color),
      .LE_x0_valid    (LE_x0_valid),
      .LE_y0_valid    (LE_y0_valid),
      .LE_x1_valid    (LE_x1_valid),
      .LE_y1_valid    (LE_y1_valid),
      .LE_color_valid (LE_color_valid),
      .LE_trigger     (LE_trigger),
      .LE_frame_base  (LE_frame_base),
      .q_busy         (q_busy)
   );

   function automatic logic [5:0] strobes();
      return {LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_color_valid, LE_trigger};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cpu_write(input logic [2:0] addr, input logic [31:0] data);
      cpu_we   = 1'b1;
      cpu_addr = addr;
      cpu_din  = data;
      @(negedge clk);
      cpu_we   = 1'b0;
   endtask

   task automatic load_cmd(input logic [9:0] x0, y0, x1, y1, input logic [31:0] col);
      cpu_write(OFF_X0, 32'(x0));
      cpu_write(OFF_Y0, 32'(y0));
      cpu_write(OFF_X1, 32'(x1));
      cpu_write(OFF_Y1, 32'(y1));
      cpu_write(OFF_COL, col);
   endtask

   // Waits for LE_x0_valid, then checks the six-cycle replay; ends on the TRIG cycle.
   task automatic run_seq(input string tag, input logic [9:0] x0, y0, x1, y1,
                          input logic [31:0] col, fb, input int limit);
      logic [9:0]  pts [4];
      logic [5:0]  stb;
      int          w;
      pts[0] = x0; pts[1] = y0; pts[2] = x1; pts[3] = y1;
      w = 0;
      while (!LE_x0_valid && w < limit) begin
         @(negedge clk);
         w++;
      end
      if (!LE_x0_valid) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      for (int s = 0; s < 6; s++) begin
         stb = 6'b100000 >> s;
         check($sformatf("%s_stb%0d", tag, s), 64'(strobes()), 64'(stb));
         check($sformatf("%s_pt%0d", tag, s), 64'(LE_point), (s < 4) ? 64'(pts[s]) : 64'd0);
         check($sformatf("%s_col%0d", tag, s), 64'(LE_color), (s == 4) ? 64'(col) : 64'd0);
         check($sformatf("%s_fb%0d", tag, s), 64'(LE_frame_base), (s == 5) ? 64'(fb) : 64'd0);
         if (s < 5) @(negedge clk);
      end
   endtask

   task automatic pulse_ready();
      LE_ready = 1'b1;
      @(negedge clk);
      LE_ready = 1'b0;
   endtask

   initial begin
      logic [5:0] seen;
      rst_n      = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = '0;
      cpu_din    = '0;
      frame_base = 32'hA000_0000;
      LE_ready   = 1'b0;
      #1;
      check("rst_dout", 64'(cpu_dout), 64'h5);
      check("rst_strobes", 64'(strobes()), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single line with engine ready: latency then ordered replay.
      LE_ready = 1'b1;
      load_cmd(10'd10, 10'd20, 10'd300, 10'd200, 32'h00FF_0000);
      cpu_write(OFF_TRIG, 32'd0);
      check("lat_cnt1", 64'(cpu_dout[15:4]), 64'd1);
      check("lat_x0_early", 64'(LE_x0_valid), 64'd0);
      @(negedge clk);
      check("lat_x0_on", 64'(LE_x0_valid), 64'd1);
      run_seq("single", 10'd10, 10'd20, 10'd300, 10'd200, 32'h00FF_0000, 32'hA000_0000, 0);
      @(negedge clk);
      check("single_cnt0", 64'(cpu_dout[15:4]), 64'd0);
      check("single_idle", 64'(strobes()), 64'd0);

      // Three queued while engine busy, drained one ready pulse at a time.
      LE_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_cmd(10'(i + 1), 10'(i + 11), 10'(i + 21), 10'(i + 31), 32'(i + 32'h100));
         cpu_write(OFF_TRIG, 32'd0);
      end
      check("three_cnt", 64'(cpu_dout[15:4]), 64'd3);
      seen = '0;
      for (int c = 0; c < 4; c++) begin
         seen |= strobes();
         @(negedge clk);
      end
      check("three_quiet", 64'(seen), 64'd0);
      for (int i = 0; i < 3; i++) begin
         pulse_ready();
         run_seq($sformatf("three%0d", i), 10'(i + 1), 10'(i + 11), 10'(i + 21),
                 10'(i + 31), 32'(i + 32'h100), 32'hA000_0000, 3);
         @(negedge clk);
         seen = '0;
         for (int c = 0; c < 3; c++) begin
            seen |= strobes();
            @(negedge clk);
         end
         check($sformatf("three%0d_wait", i), 64'(seen), 64'd0);
      end
      check("three_cnt0", 64'(cpu_dout[15:4]), 64'd0);

      // Overflow: DEPTH+1 pushes, ninth dropped, then clear.
      frame_base = 32'h2000_0000;
      load_cmd(10'd0, 10'd1, 10'd2, 10'd3, 32'h1234_5678);
      for (int i = 0; i <= DEPTH; i++) begin
         cpu_write(OFF_X0, 32'(100 + i));
         cpu_write(OFF_TRIG, 32'd0);
         if (i == DEPTH - 1) check("ovf_full_noovf", 64'(cpu_dout), 64'h86);
      end
      check("ovf_set", 64'(cpu_dout), 64'h8E);
      cpu_write(OFF_CLR, 32'd0);
      check("ovf_clr", 64'(cpu_dout), 64'h86);
      for (int i = 0; i < DEPTH; i++) begin
         pulse_ready();
         run_seq($sformatf("ovf%0d", i), 10'(100 + i), 10'd1, 10'd2, 10'd3,
                 32'h1234_5678, 32'h2000_0000, 3);
         @(negedge clk);
      end
      check("ovf_empty", 64'(cpu_dout), 64'h5);

      // Push during TRIG of a full FIFO is accepted.
      for (int i = 0; i < DEPTH; i++) begin
         cpu_write(OFF_X0, 32'(200 + i));
         cpu_write(OFF_TRIG, 32'd0);
      end
      cpu_write(OFF_X0, 32'd250);
      pulse_ready();
      run_seq("popush", 10'd200, 10'd1, 10'd2, 10'd3, 32'h1234_5678, 32'h2000_0000, 3);
      check("popush_full", 64'(cpu_dout[1]), 64'd1);
      cpu_write(OFF_TRIG, 32'd0);
      check("popush_dout", 64'(cpu_dout), 64'h86);

      // Async reset during LD_Y0 flushes everything.
      pulse_ready();
      check("rst_mid_x0", 64'(LE_point), 64'd201);
      @(negedge clk);
      check("rst_mid_y0", 64'(LE_y0_valid), 64'd1);
      LE_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_strobes", 64'(strobes()), 64'd0);
      check("rst_mid_point", 64'(LE_point), 64'd0);
      check("rst_mid_dout", 64'(cpu_dout), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         seen |= strobes();
      end
      check("rst_post_quiet", 64'(seen), 64'd0);

      // Frame base captured at push, not at drain.
      LE_ready   = 1'b0;
      frame_base = 32'h1040_0000;
      cpu_write(OFF_X0, 32'd7);
      cpu_write(OFF_TRIG, 32'd0);
      frame_base = 32'h1080_0000;
      @(negedge clk);
      pulse_ready();
      run_seq("fbcap", 10'd7, 10'd0, 10'd0, 10'd0, 32'd0, 32'h1040_0000, 3);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
